// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic instructions into 16-bit words and writes
// them to consecutive instruction-memory addresses while the core is idle.
// Word layout: {op[15:11], f1[10:8], low[7:0]}.
// Optional feature macro: INSTR_ENCODER_CHECKSUM_EN adds a 16-bit XOR
// checksum output covering every word written since start.
// Handshake: a transfer happens on a rising edge where in_valid and
// in_ready are both high; in_valid may be held, and in_ready depends only
// on the registered state and the start/finish pulses of the same cycle.
module instr_encoder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rs,
    input  logic [7:0]        in_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
`ifdef INSTR_ENCODER_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic [1:0]        dbg_state
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic [15:0]       csum_q, csum_d;

    logic              transfer;
    logic              legal;
    logic [15:0]       enc_word;

    // Pack the fields by instruction class; fields a class does not use are zero.
    function automatic logic [15:0] encode(input logic [4:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs, input logic [7:0] imm);
        logic [15:0] w;
        w = '0;
        case (op)
            5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd12: w = {op, rd, rs, 5'b0};
            5'd9, 5'd10, 5'd11:                                   w = {op, rd, imm};
            5'd13, 5'd14, 5'd15, 5'd16, 5'd17:                    w = {op, 3'b000, imm};
            default:                                              w = '0;
        endcase
        return w;
    endfunction

    assign in_ready = (state_q == S_LOAD) & ~start & ~finish;
    assign transfer = in_valid & in_ready;
    assign legal    = (in_opcode <= 5'd17);
    assign enc_word = encode(in_opcode, in_rd, in_rs, in_imm);

    // Next-state and output-register computation; start overrides everything.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        csum_d  = csum_q;
        if (start) begin
            state_d = S_LOAD;
            addr_d  = '0;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
            csum_d  = '0;
        end else if (state_q == S_LOAD) begin
            if (finish) begin
                state_d = S_DONE;
            end else if (transfer) begin
                if (legal) begin
                    // word_count doubles as the next free address; it never
                    // reaches DEPTH here because the last write leaves LOAD.
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = enc_word;
                    count_d = count_q + 1'b1;
                    csum_d  = csum_q ^ enc_word;
                    if (count_q == LAST_IDX) begin
                        full_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end
            end
        end
    end

    // State and output registers; reset drops the write strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            csum_q  <= csum_d;
        end
    end

    assign im_we      = we_q;
    assign im_addr    = addr_q;
    assign im_wdata   = wdata_q;
    assign word_count = count_q;
    assign busy       = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign full       = full_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

`ifdef INSTR_ENCODER_CHECKSUM_EN
    assign checksum = csum_q;
`else
    logic unused_csum;
    assign unused_csum = ^csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_instr_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0, finish = 1'b0, in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_opcode = '0;
  logic [2:0]        in_rd = '0, in_rs = '0;
  logic [7:0]        in_imm = '0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [15:0]       im_wdata;
  logic [ADDR_W:0]   word_count;
  logic              busy, done, full, err;
  logic [1:0]        dbg_state;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs(in_rs), .in_imm(in_imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .word_count(word_count), .busy(busy), .done(done), .full(full), .err(err),
`ifdef INSTR_ENCODER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERROR = 3;
  int          m_mode  = M_IDLE;
  logic        m_we    = 1'b0;
  int          m_addr  = 0;
  logic [15:0] m_wdata = '0;
  int          m_count = 0;
  logic        m_full  = 1'b0;
  logic        m_err   = 1'b0;
  logic [15:0] m_csum  = '0;
  logic [ADDR_W+15:0] exp_q[$];

  function automatic logic [15:0] exp_word(input int op, input int rd, input int rs, input int imm);
    if (op == 0) return 16'h0000;
    if ((op >= 1 && op <= 8) || op == 12) return 16'((op << 11) | (rd << 8) | (rs << 5));
    if (op >= 9 && op <= 11) return 16'((op << 11) | (rd << 8) | imm);
    return 16'((op << 11) | imm);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_we = 0; m_addr = 0; m_wdata = 0;
      m_count = 0; m_full = 0; m_err = 0; m_csum = 0;
      exp_q.delete();
    end else begin
      m_we = 0;
      if (start) begin
        m_mode = M_LOAD; m_addr = 0; m_count = 0; m_full = 0; m_err = 0; m_csum = 0;
      end else if (m_mode == M_LOAD) begin
        if (finish) m_mode = M_DONE;
        else if (in_valid) begin
          if (in_opcode > 17) begin
            m_err = 1; m_mode = M_ERROR;
          end else begin
            m_we = 1;
            m_addr = m_count;
            m_wdata = exp_word(in_opcode, in_rd, in_rs, in_imm);
            m_csum ^= m_wdata;
            exp_q.push_back({ADDR_W'(m_addr), m_wdata});
            m_count++;
            if (m_count == DEPTH) begin
              m_full = 1; m_mode = M_DONE;
            end
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [ADDR_W+15:0] got;
    check("in_ready", in_ready, (m_mode == M_LOAD) && !start && !finish);
    check("im_we", im_we, m_we);
    if (m_we) begin
      check("im_addr", im_addr, m_addr);
      check("im_wdata", im_wdata, m_wdata);
    end
    check("word_count", word_count, m_count);
    check("busy", busy, m_mode == M_LOAD);
    check("done", done, m_mode == M_DONE);
    check("full", full, m_full);
    check("err", err, m_err);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    check("checksum", checksum, m_csum);
`endif
    if (im_we) begin
      if (exp_q.size() == 0) check("sb_unexpected_write", 1, 0);
      else begin
        got = {im_addr, im_wdata};
        check("sb_write", got, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    start = 0; finish = 0; in_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send(input int op, input int rd, input int rs, input int imm);
    in_valid = 1; in_opcode = 5'(op); in_rd = 3'(rd); in_rs = 3'(rs); in_imm = 8'(imm);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int writes;
    idle_inputs();
    #22 rst_n = 1;
    @(posedge clk); #1;

    // reset values
    check("rst_in_ready", in_ready, 0);
    check("rst_im_we", im_we, 0);
    check("rst_im_addr", im_addr, 0);
    check("rst_im_wdata", im_wdata, 0);
    check("rst_word_count", word_count, 0);
    check("rst_busy_done_full_err", {busy, done, full, err}, 0);

    // ADD rd=1 rs=2
    pulse_start();
    check("start_busy", busy, 1);
    send(1, 1, 2, 8'hFF);
    check("add_we", im_we, 1);
    check("add_addr", im_addr, 0);
    check("add_word", im_wdata, 16'h0940);
    check("add_count", word_count, 1);
    wait_cycles(1);
    check("add_we_single", im_we, 0);

    // LI then JUMP back-to-back, rd of JUMP ignored
    pulse_start();
    send(9, 3, 5, 8'hA5);
    check("li_addr", im_addr, 0);
    check("li_word", im_wdata, 16'h4BA5);
    send(17, 7, 7, 8'h10);
    check("jump_we", im_we, 1);
    check("jump_addr", im_addr, 1);
    check("jump_word", im_wdata, 16'h8810);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    check("checksum_pair", checksum, 16'hC3B5);
`endif
    wait_cycles(1);

    // illegal opcode after two legal words
    pulse_start();
    send(5, 2, 3, 0);
    send(13, 0, 0, 8'h22);
    send(20, 1, 1, 1);
    check("ill_no_write", im_we, 0);
    check("ill_err", err, 1);
    check("ill_ready", in_ready, 0);
    check("ill_count", word_count, 2);
    check("ill_busy", busy, 0);
    wait_cycles(2);
    pulse_start();
    check("restart_err", err, 0);
    check("restart_count", word_count, 0);

    // NOPs held valid for 6 cycles: only DEPTH writes
    writes = 0;
    in_valid = 1; in_opcode = 0; in_rd = 7; in_rs = 7; in_imm = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (im_we) begin
        writes++;
        check("nop_word", im_wdata, 16'h0000);
        check("nop_addr", im_addr, writes - 1);
      end
    end
    in_valid = 0;
    check("nop_writes", writes, DEPTH);
    check("nop_full", full, 1);
    check("nop_done", done, 1);
    check("nop_ready", in_ready, 0);
    check("nop_count", word_count, DEPTH);

    // start together with a valid word after 3 writes
    pulse_start();
    send(6, 1, 2, 0);
    send(6, 2, 3, 0);
    send(6, 3, 4, 0);
    start = 1; in_valid = 1; in_opcode = 1; in_rd = 4; in_rs = 4;
    @(posedge clk); #1;
    start = 0; in_valid = 0;
    check("startx_no_write", im_we, 0);
    check("startx_count", word_count, 0);
    send(10, 5, 0, 8'h3C);
    check("startx_addr", im_addr, 0);
    check("startx_word", im_wdata, 16'h553C);
    check("startx_count1", word_count, 1);

    // reset right after a transfer
    send(7, 1, 1, 0);
    #2 rst_n = 0;
    #1;
    check("arst_we", im_we, 0);
    check("arst_count", word_count, 0);
    wait_cycles(2);
    rst_n = 1;
    wait_cycles(1);
    check("arst_idle", {in_ready, im_we, busy, done, full, err}, 0);
    check("arst_addr_data", {im_addr, im_wdata}, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start    = ($urandom_range(0, 19) == 0);
      finish   = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_opcode = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      in_rd  = 3'($urandom_range(0, 7));
      in_rs  = 3'($urandom_range(0, 7));
      in_imm = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    idle_inputs();
    wait_cycles(3);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
